// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_pkg
//  Brief    : State codes, lamp encodings and decode helpers for the
//             two-road crossing sequencer.
//  Revision : 1.0
// ============================================================================
package traffic_pkg;

    typedef enum logic [2:0] {
        S_AR_A  = 3'd0,
        S_GRN_A = 3'd1,
        S_YEL_A = 3'd2,
        S_AR_B  = 3'd3,
        S_GRN_B = 3'd4,
        S_YEL_B = 3'd5,
        S_PED   = 3'd6,
        S_EMG   = 3'd7
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef struct packed {
        logic [2:0] lights_a;
        logic [2:0] lights_b;
        logic       walk;
    } lamps_t;

    // Every state not listed keeps both roads red, so G/Y can never overlap.
    function automatic lamps_t decode_lamps(input state_t s);
        lamps_t l;
        l.lights_a = RED;
        l.lights_b = RED;
        l.walk     = 1'b0;
        case (s)
            S_GRN_A: l.lights_a = GRN;
            S_YEL_A: l.lights_a = YEL;
            S_GRN_B: l.lights_b = GRN;
            S_YEL_B: l.lights_b = YEL;
            S_PED:   l.walk     = 1'b1;
            default: ;
        endcase
        return l;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_seq_ctrl_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : phase_timer
//  Brief    : Tick prescaler plus loadable down-timer; LOAD also restarts the
//             prescaler so every phase gets whole ticks.
//  Revision : 1.0
// ============================================================================
module phase_timer #(
    parameter int            TICK_DIV = 4,
    parameter int            TW       = 3,
    parameter logic [TW-1:0] RST_VAL  = '0
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          EN,
    input  logic          LOAD,
    input  logic [TW-1:0] LOAD_VAL,
    output logic          TICK,
    output logic          ZERO,
    output logic [TW-1:0] VALUE
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] C_PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_pre;
    logic [TW-1:0] r_val;

    assign TICK  = EN && (r_pre == C_PRE_MAX);
    assign ZERO  = (r_val == '0);
    assign VALUE = r_val;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_pre <= '0;
            r_val <= RST_VAL;
        end else if (LOAD) begin
            r_pre <= '0;
            r_val <= LOAD_VAL;
        end else if (EN) begin
            r_pre <= TICK ? '0 : r_pre + 1'b1;
            if (TICK && !ZERO) begin
                r_val <= r_val - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_seq_ctrl
//  Brief    : Two-road crossing sequencer with pedestrian phase and
//             emergency all-red override.
//  Revision : 1.0
// ============================================================================
module traffic_seq_ctrl
    import traffic_pkg::*;
#(
    parameter int   TICK_DIV = 50_000_000,
    parameter int   T_GREEN  = 20,
    parameter int   T_YELLOW = 3,
    parameter int   T_ALLRED = 1,
    parameter int   T_PED    = 10,
    localparam int  TW       = $clog2(max4(T_GREEN, T_YELLOW, T_ALLRED, T_PED) + 1)
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          ENABLE,
    input  logic          PED_REQ,
    input  logic          EMERG,
    output logic [2:0]    LIGHTS_A,
    output logic [2:0]    LIGHTS_B,
    output logic          PED_WALK,
    output logic          PED_ACK,
    output logic          PED_PEND,
    output logic [TW-1:0] SEC_LEFT,
    output logic [2:0]    PHASE
);

    state_t        r_state;
    state_t        w_next;
    lamps_t        r_lamps;
    logic          r_ack;
    logic          r_pend;
    logic          r_ped_b;
    logic          w_tick;
    logic          w_zero;
    logic          w_load;
    logic          w_go_ped;
    logic [TW-1:0] w_value;

    function automatic logic [TW-1:0] phase_len(input state_t s);
        case (s)
            S_GRN_A, S_GRN_B: return TW'(T_GREEN - 1);
            S_YEL_A, S_YEL_B: return TW'(T_YELLOW - 1);
            S_AR_A,  S_AR_B:  return TW'(T_ALLRED - 1);
            S_PED:            return TW'(T_PED - 1);
            default:          return '0;
        endcase
    endfunction

    phase_timer #(
        .TICK_DIV (TICK_DIV),
        .TW       (TW),
        .RST_VAL  (TW'(T_ALLRED - 1))
    ) u_timer (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .EN       (ENABLE),
        .LOAD     (w_load),
        .LOAD_VAL (phase_len(w_next)),
        .TICK     (w_tick),
        .ZERO     (w_zero),
        .VALUE    (w_value)
    );

    // Emergency entry/exit ignores ENABLE; normal transitions need an enabled tick.
    always_comb begin
        w_next = r_state;
        if (EMERG) begin
            w_next = S_EMG;
        end else if (r_state == S_EMG) begin
            w_next = S_AR_A;
        end else if (w_tick && w_zero) begin
            case (r_state)
                S_AR_A:  w_next = r_pend ? S_PED : S_GRN_A;
                S_GRN_A: w_next = S_YEL_A;
                S_YEL_A: w_next = S_AR_B;
                S_AR_B:  w_next = r_pend ? S_PED : S_GRN_B;
                S_GRN_B: w_next = S_YEL_B;
                S_YEL_B: w_next = S_AR_A;
                S_PED:   w_next = r_ped_b ? S_GRN_B : S_GRN_A;
                default: w_next = S_AR_A;
            endcase
        end
    end

    assign w_load   = (w_next != r_state);
    assign w_go_ped = (w_next == S_PED) && (r_state != S_PED);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_AR_A;
            r_lamps <= decode_lamps(S_AR_A);
            r_ack   <= 1'b0;
            r_pend  <= 1'b0;
            r_ped_b <= 1'b0;
        end else begin
            r_state <= w_next;
            r_lamps <= decode_lamps(w_next);
            r_ack   <= w_go_ped;
            // Acceptance clears the latch even if a new request arrives that cycle.
            if (w_go_ped) begin
                r_pend  <= 1'b0;
                r_ped_b <= (r_state == S_AR_B);
            end else if (PED_REQ && (r_state != S_PED)) begin
                r_pend  <= 1'b1;
            end
        end
    end

    assign LIGHTS_A = r_lamps.lights_a;
    assign LIGHTS_B = r_lamps.lights_b;
    assign PED_WALK = r_lamps.walk;
    assign PED_ACK  = r_ack;
    assign PED_PEND = r_pend;
    assign SEC_LEFT = w_value;
    assign PHASE    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_seq_ctrl
//  Brief    : Directed, table-driven bench for traffic_seq_ctrl with small
//             timing parameters.
//  Revision : 1.0
// ============================================================================
module tb_traffic_seq_ctrl;
    import traffic_pkg::*;

    localparam int TW = 3;

    logic          CLK     = 1'b0;
    logic          RSTn    = 1'b0;
    logic          ENABLE  = 1'b0;
    logic          PED_REQ = 1'b0;
    logic          EMERG   = 1'b0;
    logic [2:0]    LIGHTS_A;
    logic [2:0]    LIGHTS_B;
    logic          PED_WALK;
    logic          PED_ACK;
    logic          PED_PEND;
    logic [TW-1:0] SEC_LEFT;
    logic [2:0]    PHASE;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] phase;
        logic [2:0] la;
        logic [2:0] lb;
        logic       walk;
        logic [2:0] sec;
        int         dur;
    } vec_t;

    vec_t seq_tbl [7];

    traffic_seq_ctrl #(
        .TICK_DIV (4),
        .T_GREEN  (5),
        .T_YELLOW (2),
        .T_ALLRED (1),
        .T_PED    (3)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .ENABLE   (ENABLE),
        .PED_REQ  (PED_REQ),
        .EMERG    (EMERG),
        .LIGHTS_A (LIGHTS_A),
        .LIGHTS_B (LIGHTS_B),
        .PED_WALK (PED_WALK),
        .PED_ACK  (PED_ACK),
        .PED_PEND (PED_PEND),
        .SEC_LEFT (SEC_LEFT),
        .PHASE    (PHASE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_phase(input string name, input logic [2:0] p);
        int n;
        n = 0;
        while (PHASE !== p && n < 300) begin
            n++;
            @(negedge CLK);
        end
        chk(name, PHASE, p);
    endtask

    task automatic measure(output int n);
        logic [2:0] p;
        p = PHASE;
        n = 0;
        while (PHASE === p && n < 300) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_phase"}, PHASE, 3'd0);
        chk({tag, "_la"},    LIGHTS_A, RED);
        chk({tag, "_lb"},    LIGHTS_B, RED);
        chk({tag, "_walk"},  PED_WALK, 1'b0);
        chk({tag, "_ack"},   PED_ACK, 1'b0);
        chk({tag, "_pend"},  PED_PEND, 1'b0);
        chk({tag, "_sec"},   SEC_LEFT, 3'd0);
    endtask

    // Continuous safety check: both roads may never show green/yellow together.
    always @(negedge CLK) begin
        if (RSTn) begin
            checks++;
            if (LIGHTS_A[1:0] != 2'b00 && LIGHTS_B[1:0] != 2'b00) begin
                errors++;
                $display("FAIL lamp_conflict: A=%b B=%b required one road red", LIGHTS_A, LIGHTS_B);
            end
        end
    end

    initial begin
        int n;
        int m;
        int period;

        seq_tbl[0] = '{3'd0, RED, RED, 1'b0, 3'd0, 4};
        seq_tbl[1] = '{3'd1, GRN, RED, 1'b0, 3'd4, 20};
        seq_tbl[2] = '{3'd2, YEL, RED, 1'b0, 3'd1, 8};
        seq_tbl[3] = '{3'd3, RED, RED, 1'b0, 3'd0, 4};
        seq_tbl[4] = '{3'd4, RED, GRN, 1'b0, 3'd4, 20};
        seq_tbl[5] = '{3'd5, RED, YEL, 1'b0, 3'd1, 8};
        seq_tbl[6] = '{3'd0, RED, RED, 1'b0, 3'd0, 4};

        // Reset state
        ENABLE = 1'b1;
        repeat (2) @(negedge CLK);
        chk_reset_vals("reset");
        RSTn = 1'b1;

        // Free-running cycle
        period = 0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("seq%0d_phase", i), PHASE,    seq_tbl[i].phase);
            chk($sformatf("seq%0d_la", i),    LIGHTS_A, seq_tbl[i].la);
            chk($sformatf("seq%0d_lb", i),    LIGHTS_B, seq_tbl[i].lb);
            chk($sformatf("seq%0d_walk", i),  PED_WALK, seq_tbl[i].walk);
            chk($sformatf("seq%0d_sec", i),   SEC_LEFT, seq_tbl[i].sec);
            measure(n);
            chk($sformatf("seq%0d_dur", i), n, seq_tbl[i].dur);
            if (i < 6) period += n;
        end
        chk("period", period, 64);

        // Pedestrian pulse in S_GRN_A, served after S_AR_B
        PED_REQ = 1'b1;
        @(negedge CLK);
        PED_REQ = 1'b0;
        chk("ped_pend_set", PED_PEND, 1'b1);
        wait_phase("ped_reach_arb", 3'd3);
        measure(n);
        chk("ped_entry_phase", PHASE, 3'd6);
        chk("ped_entry_ack", PED_ACK, 1'b1);
        chk("ped_entry_pend", PED_PEND, 1'b0);
        chk("ped_entry_walk", PED_WALK, 1'b1);
        chk("ped_entry_la", LIGHTS_A, RED);
        chk("ped_entry_lb", LIGHTS_B, RED);
        @(negedge CLK);
        chk("ped_ack_pulse", PED_ACK, 1'b0);
        measure(m);
        chk("ped_dur", m + 1, 12);
        chk("ped_return_grn_b", PHASE, 3'd4);

        // Request held across S_PED is not re-latched
        PED_REQ = 1'b1;
        @(negedge CLK);
        chk("held_pend_set", PED_PEND, 1'b1);
        wait_phase("held_reach_ped", 3'd6);
        chk("held_clear_wins", PED_PEND, 1'b0);
        measure(n);
        chk("held_return_grn_a", PHASE, 3'd1);
        chk("held_no_relatch", PED_PEND, 1'b0);
        PED_REQ = 1'b0;
        repeat (3) @(negedge CLK);
        chk("held_stays_clear", PED_PEND, 1'b0);
        PED_REQ = 1'b1;
        @(negedge CLK);
        PED_REQ = 1'b0;
        chk("rearm_pend", PED_PEND, 1'b1);
        wait_phase("rearm_ped", 3'd6);
        wait_phase("rearm_grn_b", 3'd4);

        // Emergency in S_GRN_B
        repeat (5) @(negedge CLK);
        EMERG = 1'b1;
        @(negedge CLK);
        chk("emg_phase", PHASE, 3'd7);
        chk("emg_la", LIGHTS_A, RED);
        chk("emg_lb", LIGHTS_B, RED);
        chk("emg_walk", PED_WALK, 1'b0);
        ENABLE = 1'b0;
        repeat (6) @(negedge CLK);
        chk("emg_hold_disabled", PHASE, 3'd7);
        EMERG  = 1'b0;
        ENABLE = 1'b1;
        @(negedge CLK);
        chk("emg_release_phase", PHASE, 3'd0);
        chk("emg_release_sec", SEC_LEFT, 3'd0);
        measure(n);
        chk("emg_release_dur", n, 4);
        chk("emg_to_grn_a", PHASE, 3'd1);

        // ENABLE low for 10 cycles inside S_YEL_A
        wait_phase("en_reach_yel_a", 3'd2);
        n = 0;
        while (PHASE === 3'd2 && n < 300) begin
            if (n == 3) ENABLE = 1'b0;
            if (n == 12) chk("en_frozen_sec", SEC_LEFT, 3'd1);
            if (n == 13) ENABLE = 1'b1;
            n++;
            @(negedge CLK);
        end
        chk("en_yel_dur", n, 18);
        chk("en_next_phase", PHASE, 3'd3);

        // Asynchronous reset in the middle of S_PED
        PED_REQ = 1'b1;
        @(negedge CLK);
        PED_REQ = 1'b0;
        wait_phase("rst_reach_ped", 3'd6);
        repeat (3) @(negedge CLK);
        #2 RSTn = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge CLK);
        chk("rst_no_ack", PED_ACK, 1'b0);
        RSTn = 1'b1;
        measure(n);
        chk("rst_restart_dur", n, 4);
        chk("rst_restart_grn_a", PHASE, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
